// File: rtl/clk_div_if.sv
// clk_div_if: run request, ratio handshake and divided-clock outputs of clk_div_ctrl.
interface clk_div_if #(
    parameter int CNT_W = 8
);
    logic             en;
    logic             div_valid;
    logic [CNT_W-1:0] div_value;
    logic             div_ready;
    logic [CNT_W-1:0] div_active;
    logic             busy;
    logic             err;
    logic             clk_div;
    logic             tick;
    modport master (
        output en, div_valid, div_value,
        input  div_ready, div_active, busy, err, clk_div, tick
    );
    modport slave (
        input  en, div_valid, div_value,
        output div_ready, div_active, busy, err, clk_div, tick
    );
endinterface

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: programmable clock divider; new ratios take effect only at a period boundary.
module clk_div_ctrl #(
    parameter int CNT_W   = 8,
    parameter int DEF_DIV = 3
) (
    input logic       clk,
    input logic       rst,
    clk_div_if.slave  bus
);
    typedef enum logic {OFF, RUN} state_t;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] pval_q, pval_d;
    logic             pend_q, pend_d;
    logic             err_q, err_d;
    logic             wrap, accept, bad, apply;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= OFF;
            cnt_q   <= '0;
            div_q   <= CNT_W'(DEF_DIV);
            pval_q  <= '0;
            pend_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            pval_q  <= pval_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
        end
    end
    // Accept and apply are mutually exclusive: accept needs !pend_q, apply needs pend_q.
    always_comb begin
        wrap    = (state_q == RUN) && (cnt_q == div_q - CNT_W'(1));
        accept  = bus.div_valid && !pend_q;
        bad     = bus.div_value < CNT_W'(2);
        apply   = pend_q && ((state_q == OFF) || wrap);
        state_d = state_q;
        if (state_q == OFF && bus.en)
            state_d = RUN;
        else if (wrap && !bus.en)
            state_d = OFF;
        cnt_d  = (state_q == OFF || wrap) ? '0 : cnt_q + CNT_W'(1);
        div_d  = apply ? pval_q : div_q;
        pend_d = apply ? 1'b0 : (accept && !bad) ? 1'b1 : pend_q;
        pval_d = (accept && !bad) ? bus.div_value : pval_q;
        err_d  = accept && bad;
    end
    assign bus.clk_div    = (state_q == RUN) && (cnt_q < (div_q >> 1));
    assign bus.tick       = (state_q == RUN) && (cnt_q == '0);
    assign bus.div_ready  = !pend_q;
    assign bus.busy       = pend_q;
    assign bus.div_active = div_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb_clk_div_ctrl: directed vector table plus hand sequences for max ratio and zero ratio.
module tb_clk_div_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    clk_div_if #(.CNT_W(8)) bus();
    clk_div_ctrl #(.CNT_W(8), .DEF_DIV(3)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );
    always #5 clk = ~clk;
    typedef struct {
        logic       rst, en, vld;
        logic [7:0] val;
        logic       cd, tk, rdy, bsy, er;
        logic [7:0] act;
    } vec_t;
    vec_t vecs[$];
    function automatic void add(logic r, logic e, logic v, logic [7:0] d,
                                logic cd, logic tk, logic rdy, logic bsy, logic er, logic [7:0] act);
        vec_t x;
        x.rst = r; x.en = e; x.vld = v; x.val = d;
        x.cd = cd; x.tk = tk; x.rdy = rdy; x.bsy = bsy; x.er = er; x.act = act;
        vecs.push_back(x);
    endfunction
    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    int hi, tk;
    initial begin
        bus.en = 1'b0; bus.div_valid = 1'b0; bus.div_value = '0;
        // rst en vld val | clk_div tick ready busy err active
        add(1,0,0,0, 0,0,1,0,0,3);
        add(1,0,0,0, 0,0,1,0,0,3);
        add(0,1,0,0, 1,1,1,0,0,3);
        add(0,1,0,0, 0,0,1,0,0,3);
        add(0,1,0,0, 0,0,1,0,0,3);
        add(0,1,0,0, 1,1,1,0,0,3);
        add(0,1,0,0, 0,0,1,0,0,3);
        add(0,1,1,5, 0,0,0,1,0,3);
        add(0,1,0,0, 1,1,1,0,0,5);
        add(0,1,0,0, 1,0,1,0,0,5);
        add(0,1,0,0, 0,0,1,0,0,5);
        add(0,1,0,0, 0,0,1,0,0,5);
        add(0,1,0,0, 0,0,1,0,0,5);
        add(0,1,0,0, 1,1,1,0,0,5);
        add(0,1,1,1, 1,0,1,0,1,5);
        add(0,1,0,0, 0,0,1,0,0,5);
        add(0,1,1,4, 0,0,0,1,0,5);
        add(0,1,1,6, 0,0,0,1,0,5);
        add(0,1,1,6, 1,1,1,0,0,4);
        add(0,1,1,6, 1,0,0,1,0,4);
        add(0,1,0,0, 0,0,0,1,0,4);
        add(0,1,0,0, 0,0,0,1,0,4);
        add(0,1,0,0, 1,1,1,0,0,6);
        add(0,1,1,5, 1,0,0,1,0,6);
        add(0,1,0,0, 1,0,0,1,0,6);
        add(0,1,0,0, 0,0,0,1,0,6);
        add(0,1,0,0, 0,0,0,1,0,6);
        add(0,1,0,0, 0,0,0,1,0,6);
        add(0,1,0,0, 1,1,1,0,0,5);
        add(0,1,0,0, 1,0,1,0,0,5);
        add(0,0,0,0, 0,0,1,0,0,5);
        add(0,0,0,0, 0,0,1,0,0,5);
        add(0,0,0,0, 0,0,1,0,0,5);
        add(0,0,0,0, 0,0,1,0,0,5);
        add(0,0,0,0, 0,0,1,0,0,5);
        add(0,1,0,0, 1,1,1,0,0,5);
        add(0,1,0,0, 1,0,1,0,0,5);
        add(0,0,0,0, 0,0,1,0,0,5);
        add(0,0,0,0, 0,0,1,0,0,5);
        add(0,0,0,0, 0,0,1,0,0,5);
        add(0,0,0,0, 0,0,1,0,0,5);
        add(0,0,1,2, 0,0,0,1,0,5);
        add(0,1,0,0, 1,1,1,0,0,2);
        add(0,1,0,0, 0,0,1,0,0,2);
        add(0,1,0,0, 1,1,1,0,0,2);
        add(0,1,0,0, 0,0,1,0,0,2);
        add(0,1,1,3, 1,1,0,1,0,2);
        add(0,1,0,0, 0,0,0,1,0,2);
        add(0,1,0,0, 1,1,1,0,0,3);
        add(0,1,0,0, 0,0,1,0,0,3);
        add(0,1,1,7, 0,0,0,1,0,3);
        add(1,1,0,0, 0,0,1,0,0,3);
        add(0,0,0,0, 0,0,1,0,0,3);
        foreach (vecs[i]) begin
            rst = vecs[i].rst;
            bus.en = vecs[i].en;
            bus.div_valid = vecs[i].vld;
            bus.div_value = vecs[i].val;
            step();
            chk($sformatf("row%0d clk_div", i), 32'(bus.clk_div), 32'(vecs[i].cd));
            chk($sformatf("row%0d tick", i), 32'(bus.tick), 32'(vecs[i].tk));
            chk($sformatf("row%0d ready", i), 32'(bus.div_ready), 32'(vecs[i].rdy));
            chk($sformatf("row%0d busy", i), 32'(bus.busy), 32'(vecs[i].bsy));
            chk($sformatf("row%0d err", i), 32'(bus.err), 32'(vecs[i].er));
            chk($sformatf("row%0d active", i), 32'(bus.div_active), 32'(vecs[i].act));
        end
        // Zero ratio is rejected with a single-cycle err.
        bus.div_valid = 1'b1; bus.div_value = 8'd0;
        step();
        chk("zero err", 32'(bus.err), 32'd1);
        chk("zero busy", 32'(bus.busy), 32'd0);
        bus.div_valid = 1'b0;
        step();
        chk("zero err drop", 32'(bus.err), 32'd0);
        chk("zero active", 32'(bus.div_active), 32'd3);
        // Largest ratio: 255-cycle period with 127 high cycles.
        bus.div_valid = 1'b1; bus.div_value = 8'd255;
        step();
        bus.div_valid = 1'b0;
        step();
        chk("max active", 32'(bus.div_active), 32'd255);
        chk("max busy", 32'(bus.busy), 32'd0);
        bus.en = 1'b1;
        step();
        chk("max first tick", 32'(bus.tick), 32'd1);
        hi = 0; tk = 0;
        for (int i = 0; i < 255; i++) begin
            hi += int'(bus.clk_div);
            tk += int'(bus.tick);
            step();
        end
        chk("max high cycles", 32'(hi), 32'd127);
        chk("max ticks", 32'(tk), 32'd1);
        chk("max wrap tick", 32'(bus.tick), 32'd1);
        chk("max wrap clk_div", 32'(bus.clk_div), 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
